// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: select codes of the
// attached alu_32_bit and the sequencer FSM state encoding.
package alu_cmd_sequencer_pkg;

  localparam int ALU_OP_W = 3;

  // {S2,S1,S0} codes: S2=0 selects arithmetic (carry-in added), S2=1 logic.
  localparam logic [ALU_OP_W-1:0] ALU_OP_TFR_A = 3'b000; // F = A + Ci
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 3'b001; // F = A + B + Ci
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 3'b010; // F = A + ~B + Ci
  localparam logic [ALU_OP_W-1:0] ALU_OP_DEC   = 3'b011; // F = A - 1 + Ci
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR    = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR   = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND   = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOT_A = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Sequences one command at a time into the combinational alu_32_bit, holds the
// operands while it settles, then returns the captured F/Co on a result channel.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  // Both channels: a transfer happens on a rising edge where valid & ready;
  // the sender keeps valid and its payload stable until that edge.
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ALU_OP_W-1:0] cmd_op,
  input  logic [WIDTH-1:0]    cmd_a,
  input  logic [WIDTH-1:0]    cmd_b,
  input  logic                cmd_ci,
  input  logic                cmd_chain,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic                alu_s0,
  output logic                alu_s1,
  output logic                alu_s2,
  output logic                alu_ci,
  input  logic [WIDTH-1:0]    alu_f,
  input  logic                alu_co,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WIDTH-1:0]    res_f,
  output logic                res_co,
  output logic [CNT_W-1:0]    op_count,
  output logic [1:0]          dbg_state
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(1);

  seq_state_t      state;
  logic [SC_W-1:0] settle_cnt;
  logic            carry;

  assign cmd_ready = (state == ST_IDLE);
  assign dbg_state = state;

  // The operands are already stable during the first cycle after accept, so
  // SETTLE itself only has to cover the remaining SETTLE_CYCLES-1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      carry      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s0     <= 1'b0;
      alu_s1     <= 1'b0;
      alu_s2     <= 1'b0;
      alu_ci     <= 1'b0;
      res_valid  <= 1'b0;
      res_f      <= '0;
      res_co     <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_s0     <= cmd_op[0];
            alu_s1     <= cmd_op[1];
            alu_s2     <= cmd_op[2];
            alu_ci     <= cmd_chain ? carry : cmd_ci;
            settle_cnt <= SETTLE_LOAD;
            state      <= (SETTLE_CYCLES > 1) ? ST_SETTLE : ST_CAPTURE;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          res_f     <= alu_f;
          res_co    <= alu_co;
          carry     <= alu_co;
          res_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
